// File: rtl/hamming_minmax_engine_if.sv
// Bus bundle for hamming_minmax_engine: start/done handshake, memory read port and results.
// The pair-index signals exist only when HAM_PAIR_IDX_EN is defined.
interface hamming_minmax_engine_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 8
);
  localparam int DW = $clog2(WIDTH + 1);

  logic             start;
  logic             done;
  logic             mem_rd_en;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic [DW-1:0]    min_dist;
  logic [DW-1:0]    max_dist;

`ifdef HAM_PAIR_IDX_EN
  localparam int IW = $clog2(DEPTH);
  logic [IW-1:0]    min_idx_a;
  logic [IW-1:0]    min_idx_b;
  logic [IW-1:0]    max_idx_a;
  logic [IW-1:0]    max_idx_b;

  modport master (
    input  start, mem_rdata,
    output done, mem_rd_en, mem_addr, min_dist, max_dist,
           min_idx_a, min_idx_b, max_idx_a, max_idx_b
  );
  modport slave (
    output start, mem_rdata,
    input  done, mem_rd_en, mem_addr, min_dist, max_dist,
           min_idx_a, min_idx_b, max_idx_a, max_idx_b
  );
`else
  modport master (
    input  start, mem_rdata,
    output done, mem_rd_en, mem_addr, min_dist, max_dist
  );
  modport slave (
    output start, mem_rdata,
    input  done, mem_rd_en, mem_addr, min_dist, max_dist
  );
`endif
endinterface

// File: rtl/hamming_minmax_engine.sv
// Min/max pairwise Hamming distance over DEPTH operands read from an external memory.
// Optional feature macro HAM_PAIR_IDX_EN adds the index pair behind each extreme.
module hamming_minmax_engine #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 8,
  parameter int BASE  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hamming_minmax_engine_if.master bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int DW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, RD_A, STREAM, DRAIN, DONE} state_t;

  state_t           state_reg;
  logic             start_q;
  logic [IW-1:0]    j_reg;
  logic [IW-1:0]    k_reg;
  logic             drain_reg;
  logic             a_pend_reg;
  logic             b_vld_reg;
  logic             d_vld_reg;
  logic [WIDTH-1:0] a_reg;
  logic [DW-1:0]    dist_reg;
  logic [WIDTH-1:0] diff;
  logic [DW-1:0]    dist_next;
`ifdef HAM_PAIR_IDX_EN
  logic [IW-1:0]    bj_reg, bk_reg, dj_reg, dk_reg;
`endif

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_diff
    assign diff[gi] = a_reg[gi] ^ bus.mem_rdata[gi];
  end

  always_comb begin
    dist_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dist_next = dist_next + DW'(diff[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      start_q       <= 1'b0;
      j_reg         <= '0;
      k_reg         <= '0;
      drain_reg     <= 1'b0;
      a_pend_reg    <= 1'b0;
      b_vld_reg     <= 1'b0;
      d_vld_reg     <= 1'b0;
      a_reg         <= '0;
      dist_reg      <= '0;
      bus.done      <= 1'b0;
      bus.mem_rd_en <= 1'b0;
      bus.mem_addr  <= '0;
      bus.min_dist  <= DW'(WIDTH);
      bus.max_dist  <= '0;
`ifdef HAM_PAIR_IDX_EN
      bj_reg        <= '0;
      bk_reg        <= '0;
      dj_reg        <= '0;
      dk_reg        <= '0;
      bus.min_idx_a <= '0;
      bus.min_idx_b <= '0;
      bus.max_idx_a <= '0;
      bus.max_idx_b <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          start_q       <= bus.start;
          bus.done      <= 1'b0;
          bus.mem_rd_en <= 1'b0;
          a_pend_reg    <= 1'b0;
          b_vld_reg     <= 1'b0;
          d_vld_reg     <= 1'b0;
          if (start_q && !bus.start) begin
            bus.min_dist  <= DW'(WIDTH);
            bus.max_dist  <= '0;
            j_reg         <= '0;
            bus.mem_rd_en <= 1'b1;
            bus.mem_addr  <= AW'(BASE);
            state_reg     <= RD_A;
`ifdef HAM_PAIR_IDX_EN
            // Seed with the first pair so a never-beaten extreme still names (0,1).
            bus.min_idx_a <= '0;
            bus.min_idx_b <= IW'(1);
            bus.max_idx_a <= '0;
            bus.max_idx_b <= IW'(1);
`endif
          end
        end

        RD_A, STREAM, DRAIN: begin
          if (bus.start) begin
            state_reg     <= IDLE;
            bus.mem_rd_en <= 1'b0;
            a_pend_reg    <= 1'b0;
            b_vld_reg     <= 1'b0;
            d_vld_reg     <= 1'b0;
          end else begin
            // Pipeline: read -> capture A / present B -> register dist -> compare.
            a_pend_reg <= (state_reg == RD_A);
            b_vld_reg  <= (state_reg == STREAM);
            d_vld_reg  <= b_vld_reg;
            dist_reg   <= dist_next;
            if (a_pend_reg) begin
              a_reg <= bus.mem_rdata;
            end
`ifdef HAM_PAIR_IDX_EN
            bj_reg <= j_reg;
            bk_reg <= k_reg;
            dj_reg <= bj_reg;
            dk_reg <= bk_reg;
`endif
            if (d_vld_reg && (dist_reg < bus.min_dist)) begin
              bus.min_dist  <= dist_reg;
`ifdef HAM_PAIR_IDX_EN
              bus.min_idx_a <= dj_reg;
              bus.min_idx_b <= dk_reg;
`endif
            end
            if (d_vld_reg && (dist_reg > bus.max_dist)) begin
              bus.max_dist  <= dist_reg;
`ifdef HAM_PAIR_IDX_EN
              bus.max_idx_a <= dj_reg;
              bus.max_idx_b <= dk_reg;
`endif
            end

            if (state_reg == RD_A) begin
              k_reg        <= j_reg + IW'(1);
              bus.mem_addr <= AW'(BASE) + AW'(j_reg) + AW'(1);
              state_reg    <= STREAM;
            end else if (state_reg == STREAM) begin
              if (k_reg == IW'(DEPTH - 1)) begin
                if (j_reg == IW'(DEPTH - 2)) begin
                  bus.mem_rd_en <= 1'b0;
                  drain_reg     <= 1'b0;
                  state_reg     <= DRAIN;
                end else begin
                  j_reg        <= j_reg + IW'(1);
                  bus.mem_addr <= AW'(BASE) + AW'(j_reg) + AW'(1);
                  state_reg    <= RD_A;
                end
              end else begin
                k_reg        <= k_reg + IW'(1);
                bus.mem_addr <= AW'(BASE) + AW'(k_reg) + AW'(1);
              end
            end else begin
              drain_reg <= 1'b1;
              if (drain_reg) begin
                state_reg <= DONE;
              end
            end
          end
        end

        DONE: begin
          if (bus.start) begin
            state_reg <= IDLE;
          end else begin
            bus.done <= 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hamming_minmax_engine.sv
// Bench for hamming_minmax_engine: a 16x32 instance (BASE=4) and an 8x3 instance,
// each against a pair-enumerating reference model over a behavioural memory.
module tb_hamming_minmax_engine;
  localparam int BW = 16, BD = 32, BAW = 8, BB = 4;
  localparam int SW = 8,  SD = 3,  SAW = 4, SB = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  hamming_minmax_engine_if #(.WIDTH(BW), .DEPTH(BD), .AW(BAW)) bb ();
  hamming_minmax_engine_if #(.WIDTH(SW), .DEPTH(SD), .AW(SAW)) sb ();

  hamming_minmax_engine #(.WIDTH(BW), .DEPTH(BD), .AW(BAW), .BASE(BB)) u_big (
    .clk(clk), .rst_n(rst_n), .bus(bb)
  );
  hamming_minmax_engine #(.WIDTH(SW), .DEPTH(SD), .AW(SAW), .BASE(SB)) u_small (
    .clk(clk), .rst_n(rst_n), .bus(sb)
  );

  logic [BW-1:0] mem_big   [0:(1<<BAW)-1];
  logic [SW-1:0] mem_small [0:(1<<SAW)-1];

  always @(posedge clk) begin
    if (bb.mem_rd_en) bb.mem_rdata <= mem_big[bb.mem_addr];
    if (sb.mem_rd_en) sb.mem_rdata <= mem_small[sb.mem_addr];
  end

  int exp_min, exp_max, exp_mia, exp_mib, exp_maa, exp_mab;

  function automatic int exp_latency(input int d);
    return (d - 1) + d * (d - 1) / 2 + 3;
  endfunction

  function automatic int exp_reads(input int d);
    return (d - 1) + d * (d - 1) / 2;
  endfunction

  // Enumerate every unordered pair in (j,k) order; keep the first strict extreme.
  task automatic model(input bit big);
    int n = big ? BD : SD;
    int w = big ? BW : SW;
    logic [31:0] v[$];
    for (int i = 0; i < n; i++)
      v.push_back(big ? 32'(mem_big[BB + i]) : 32'(mem_small[SB + i]));
    exp_min = w; exp_max = 0;
    exp_mia = 0; exp_mib = 1; exp_maa = 0; exp_mab = 1;
    for (int j = 0; j < n; j++) begin
      for (int k = j + 1; k < n; k++) begin
        int d = $countones(v[j] ^ v[k]);
        if (d < exp_min) begin exp_min = d; exp_mia = j; exp_mib = k; end
        if (d > exp_max) begin exp_max = d; exp_maa = j; exp_mab = k; end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit big, input logic v);
    if (big) bb.start = v;
    else     sb.start = v;
  endtask

  task automatic launch(input bit big);
    @(negedge clk); set_start(big, 1'b1);
    repeat (2) @(negedge clk);
    set_start(big, 1'b0);
    @(posedge clk);
  endtask

  // Launch, then count edges until done (bounded) and read strobes seen on the way.
  task automatic run(input bit big, output int lat, output int rds);
    launch(big);
    #1;
    rds = (big ? bb.mem_rd_en : sb.mem_rd_en) ? 1 : 0;
    lat = 0;
    while (!(big ? bb.done : sb.done) && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (big ? bb.mem_rd_en : sb.mem_rd_en) rds++;
    end
  endtask

  task automatic check_results(input bit big, input string pfx);
    check({pfx, "_min"}, big ? 32'(bb.min_dist) : 32'(sb.min_dist), exp_min);
    check({pfx, "_max"}, big ? 32'(bb.max_dist) : 32'(sb.max_dist), exp_max);
`ifdef HAM_PAIR_IDX_EN
    check({pfx, "_min_a"}, big ? 32'(bb.min_idx_a) : 32'(sb.min_idx_a), exp_mia);
    check({pfx, "_min_b"}, big ? 32'(bb.min_idx_b) : 32'(sb.min_idx_b), exp_mib);
    check({pfx, "_max_a"}, big ? 32'(bb.max_idx_a) : 32'(sb.max_idx_a), exp_maa);
    check({pfx, "_max_b"}, big ? 32'(bb.max_idx_b) : 32'(sb.max_idx_b), exp_mab);
`endif
  endtask

  task automatic full_run(input bit big, input string pfx);
    int lat, rds, d;
    d = big ? BD : SD;
    model(big);
    run(big, lat, rds);
    $display("run %s: latency=%0d reads=%0d min=%0d max=%0d", pfx, lat, rds,
             big ? bb.min_dist : 5'(sb.min_dist), big ? bb.max_dist : 5'(sb.max_dist));
    check({pfx, "_lat"}, lat, exp_latency(d));
    check({pfx, "_reads"}, rds, exp_reads(d));
    check_results(big, pfx);
  endtask

  initial begin
    int seen_done;
    bb.start = 1'b1;
    sb.start = 1'b1;
    for (int i = 0; i < (1 << BAW); i++) mem_big[i] = '0;
    for (int i = 0; i < (1 << SAW); i++) mem_small[i] = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_done", bb.done, 0);
    check("rst_rd_en", bb.mem_rd_en, 0);
    check("rst_addr", bb.mem_addr, 0);
    check("rst_min", bb.min_dist, BW);
    check("rst_max", bb.max_dist, 0);
    check("rst_small_min", sb.min_dist, SW);
`ifdef HAM_PAIR_IDX_EN
    check("rst_idx", {bb.min_idx_a, bb.min_idx_b, bb.max_idx_a, bb.max_idx_b}, 0);
`endif
    rst_n = 1'b1;

    // All-zero operands.
    full_run(1'b1, "zero");

    // done holds while start stays low, then clears one edge after start returns high.
    repeat (5) @(posedge clk);
    #1 check("hold_done", bb.done, 1);
    @(negedge clk) bb.start = 1'b1;
    @(posedge clk); #1 check("exit_done_still", bb.done, 1);
    @(posedge clk); #1 check("exit_done_clear", bb.done, 0);
    check("exit_min_kept", bb.min_dist, exp_min);

    // One all-ones operand.
    mem_big[BB] = 16'hFFFF;
    full_run(1'b1, "ones0");

    // Random operands.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < BD; i++) mem_big[BB + i] = 16'($urandom);
      full_run(1'b1, $sformatf("rand%0d", r));
    end

    // Abort at edge 100 of a run, then relaunch on the same data.
    for (int i = 0; i < BD; i++) mem_big[BB + i] = 16'($urandom);
    launch(1'b1);
    repeat (99) @(posedge clk);
    @(negedge clk) bb.start = 1'b1;
    @(posedge clk); #1 check("abort_rd_en", bb.mem_rd_en, 0);
    seen_done = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (bb.done) seen_done = 1;
    end
    check("abort_no_done", seen_done, 0);
    full_run(1'b1, "relaunch");

    // Asynchronous reset mid-STREAM.
    for (int i = 0; i < BD; i++) mem_big[BB + i] = 16'($urandom);
    launch(1'b1);
    repeat (60) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("arst_done", bb.done, 0);
    check("arst_rd_en", bb.mem_rd_en, 0);
    check("arst_addr", bb.mem_addr, 0);
    check("arst_min", bb.min_dist, BW);
    check("arst_max", bb.max_dist, 0);
    @(negedge clk) rst_n = 1'b1;
    full_run(1'b1, "post_rst");

    // Small instance: {00, 0F, FF}.
    mem_small[SB + 0] = 8'h00;
    mem_small[SB + 1] = 8'h0F;
    mem_small[SB + 2] = 8'hFF;
    full_run(1'b0, "small");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
